// File: rtl/uart_pkg.sv
// Shared register-map constants and FSM state encodings for the UART MMIO responder.
package uart_pkg;

    localparam logic UART_DATA_SEL = 1'b0;
    localparam logic UART_STAT_SEL = 1'b1;

    localparam int RXDP   = 0;
    localparam int TXFULL = 1;
    localparam int OVR    = 2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with extra-MSB pointers; head is visible combinationally on dout.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    // A push into a full FIFO is still accepted when a pop frees a slot the same cycle.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// MMIO UART: DATA/STATUS register window, FIFO-backed 8N1 transmitter and receiver.
// Handshake: tx_wen/rx_ren are one-cycle strobes; uart_dout is valid in the strobe cycle.
module uart_mmio_responder
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_wen,
    input  logic       rx_ren,
    input  logic [7:0] uart_din,
    input  logic [2:0] uart_addr,
    output logic [7:0] uart_dout,
    output logic       tx_full,
    output logic       rx_data_present,
    output logic       txd,
    input  logic       rxd
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic addr_sel;
    logic unused_addr_bits;

    logic       tx_push, tx_pop, tx_fifo_full, tx_fifo_empty;
    logic [7:0] tx_fifo_dout;
    logic       rx_push, rx_pop, rx_fifo_full, rx_fifo_empty;
    logic [7:0] rx_fifo_dout;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic          rx_overrun_q, rx_overrun_d;
    logic          rx_fall;

    assign addr_sel         = uart_addr[2];
    assign unused_addr_bits = ^uart_addr[1:0];

    assign tx_push = tx_wen && (addr_sel == UART_DATA_SEL) && !tx_fifo_full;
    assign rx_pop  = rx_ren && (addr_sel == UART_DATA_SEL) && !rx_fifo_empty;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(uart_din),
        .dout(tx_fifo_dout), .full(tx_fifo_full), .empty(tx_fifo_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_shift_q),
        .dout(rx_fifo_dout), .full(rx_fifo_full), .empty(rx_fifo_empty)
    );

    // txd is registered from the current state, so the line trails the state by one cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_fifo_dout;
                    tx_cnt_d   = BAUD_LAST;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = BAUD_LAST;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = BAUD_LAST;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    if (!tx_fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_fifo_dout;
                        tx_cnt_d   = BAUD_LAST;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_q)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_shift_q[0];
            default:  txd_d = 1'b1;
        endcase
    end

    assign rx_fall = rx_prev_q && !rx_sync2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_d   = HALF_LAST;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    rx_cnt_d   = BAUD_LAST;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_cnt_d   = BAUD_LAST;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_push    = rx_sync2_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A new overrun in the same cycle as a STATUS read wins over the clear.
    always_comb begin
        rx_overrun_d = rx_overrun_q;
        if (rx_ren && (addr_sel == UART_STAT_SEL)) begin
            rx_overrun_d = 1'b0;
        end
        if (rx_push && rx_fifo_full && !rx_pop) begin
            rx_overrun_d = 1'b1;
        end
    end

    always_comb begin
        uart_dout = 8'h00;
        if (addr_sel == UART_STAT_SEL) begin
            uart_dout[RXDP]   = !rx_fifo_empty;
            uart_dout[TXFULL] = tx_fifo_full;
            uart_dout[OVR]    = rx_overrun_q;
        end else if (!rx_fifo_empty) begin
            uart_dout = rx_fifo_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            txd_q        <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_sync1_q   <= 1'b1;
            rx_sync2_q   <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_overrun_q <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            txd_q        <= txd_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_sync1_q   <= rxd;
            rx_sync2_q   <= rx_sync1_q;
            rx_prev_q    <= rx_sync2_q;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign txd             = txd_q;
    assign tx_full         = tx_fifo_full;
    assign rx_data_present = !rx_fifo_empty;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Bench for uart_mmio_responder: random bytes through TX/RX checked against a queue-based model.
module tb_uart_mmio_responder;
    localparam int BAUD  = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_wen = 1'b0;
    logic       rx_ren = 1'b0;
    logic [7:0] uart_din = 8'h00;
    logic [2:0] uart_addr = 3'd0;
    logic [7:0] uart_dout;
    logic       tx_full;
    logic       rx_data_present;
    logic       txd;
    logic       rxd = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] tx_seen_q[$];
    logic       tx_stop_q[$];
    int         tx_start_q[$];

    uart_mmio_responder #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_wen(tx_wen), .rx_ren(rx_ren),
        .uart_din(uart_din), .uart_addr(uart_addr), .uart_dout(uart_dout),
        .tx_full(tx_full), .rx_data_present(rx_data_present),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: decodes frames on txd by sampling near each bit centre.
    initial begin
        logic [7:0] b;
        int st;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                st = cyc;
                repeat (BAUD / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (BAUD) @(negedge clk);
                    b[k] = txd;
                end
                repeat (BAUD) @(negedge clk);
                tx_stop_q.push_back(txd);
                tx_seen_q.push_back(b);
                tx_start_q.push_back(st);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [2:0] data_off();
        return 3'($urandom_range(3, 0));
    endfunction

    function automatic logic [2:0] stat_off();
        return 3'($urandom_range(7, 4));
    endfunction

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        uart_addr = a;
        uart_din  = d;
        tx_wen    = 1'b1;
        @(negedge clk);
        tx_wen = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        uart_addr = a;
        rx_ren    = 1'b1;
        #1 d = uart_dout;
        @(negedge clk);
        rx_ren = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BAUD - 1) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rxd = b[k];
            repeat (BAUD - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = stop_bit;
        repeat (BAUD - 1) @(negedge clk);
        @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
        total++;
        if (tx_full !== 1'b0) begin bad++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
        total++;
        if (rx_data_present !== 1'b0) begin bad++; $display("FAIL reset_rxdp: got %b want 0", rx_data_present); end
        uart_addr = 3'd4;
        #1;
        total++;
        if (uart_dout !== 8'h00) begin bad++; $display("FAIL reset_status: got %h want 00", uart_dout); end
        uart_addr = 3'd0;
        #1;
        total++;
        if (uart_dout !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", uart_dout); end
    endtask

    task automatic test_tx_single(input logic [7:0] data);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        write_reg(data_off(), data);
        @(negedge clk);
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL tx_pre_start: got %b want 1", txd); end
        for (int i = 0; i < 10 * BAUD; i++) begin
            @(negedge clk);
            total++;
            if (txd !== frame[i / BAUD]) begin
                bad++;
                $display("FAIL tx_frame_bit data=%h cycle=%0d: got %b want %b", data, i, txd, frame[i / BAUD]);
            end
        end
        @(negedge clk);
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL tx_post_idle: got %b want 1", txd); end
    endtask

    task automatic test_status_write_ignored();
        tx_seen_q.delete();
        write_reg(stat_off(), 8'($urandom));
        repeat (60) @(negedge clk);
        total++;
        if (tx_seen_q.size() != 0) begin bad++; $display("FAIL status_write_frames: got %0d want 0", tx_seen_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int occ;
        int t;
        tx_seen_q.delete();
        tx_stop_q.delete();
        tx_start_q.delete();
        b = 8'($urandom);
        exp_q.push_back(b);
        write_reg(data_off(), b);
        t = 0;
        while (txd !== 1'b0 && t < 10) begin @(negedge clk); t++; end
        total++;
        if (txd !== 1'b0) begin bad++; $display("FAIL b2b_prime_start: got %b want 0", txd); end
        occ = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            uart_din  = b;
            uart_addr = data_off();
            tx_wen    = 1'b1;
            if (occ < DEPTH) begin exp_q.push_back(b); occ++; end
            @(negedge clk);
            total++;
            if (tx_full !== (occ == DEPTH)) begin
                bad++;
                $display("FAIL b2b_tx_full write=%0d: got %b want %b", i, tx_full, occ == DEPTH);
            end
        end
        tx_wen = 1'b0;
        t = 0;
        while (tx_seen_q.size() < exp_q.size() && t < 600) begin @(negedge clk); t++; end
        total++;
        if (tx_seen_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL b2b_frame_count: got %0d want %0d", tx_seen_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < tx_seen_q.size(); i++) begin
            total++;
            if (tx_seen_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_byte idx=%0d: got %h want %h", i, tx_seen_q[i], exp_q[i]);
            end
            total++;
            if (tx_stop_q[i] !== 1'b1) begin bad++; $display("FAIL b2b_stop idx=%0d: got %b want 1", i, tx_stop_q[i]); end
            if (i > 0) begin
                total++;
                if (tx_start_q[i] - tx_start_q[i-1] != 10 * BAUD) begin
                    bad++;
                    $display("FAIL b2b_gap idx=%0d: got %0d want %0d", i, tx_start_q[i] - tx_start_q[i-1], 10 * BAUD);
                end
            end
        end
        repeat (60) @(negedge clk);
        total++;
        if (tx_seen_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL b2b_no_extra: got %0d want %0d", tx_seen_q.size(), exp_q.size());
        end
        total++;
        if (tx_full !== 1'b0) begin bad++; $display("FAIL b2b_full_clear: got %b want 0", tx_full); end
    endtask

    task automatic test_rx_single(input logic [7:0] data);
        logic [7:0] d;
        int t;
        send_rx(data, 1'b1);
        t = 0;
        while (rx_data_present !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        total++;
        if (rx_data_present !== 1'b1) begin bad++; $display("FAIL rx_present: got %b want 1", rx_data_present); end
        read_reg(stat_off(), d);
        total++;
        if (d !== 8'h01) begin bad++; $display("FAIL rx_status: got %h want 01", d); end
        read_reg(data_off(), d);
        total++;
        if (d !== data) begin bad++; $display("FAIL rx_data: got %h want %h", d, data); end
        total++;
        if (rx_data_present !== 1'b0) begin bad++; $display("FAIL rx_present_clear: got %b want 0", rx_data_present); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [7:0] d;
        logic       ovr;
        ovr = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else ovr = 1'b1;
            send_rx(b, 1'b1);
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        read_reg(stat_off(), d);
        total++;
        if (d !== {5'b0, ovr, 1'b0, exp_q.size() != 0}) begin
            bad++;
            $display("FAIL ovr_status1: got %h want %h", d, {5'b0, ovr, 1'b0, exp_q.size() != 0});
        end
        read_reg(stat_off(), d);
        total++;
        if (d !== {7'b0, exp_q.size() != 0}) begin
            bad++;
            $display("FAIL ovr_status2: got %h want %h", d, {7'b0, exp_q.size() != 0});
        end
        while (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            read_reg(data_off(), d);
            total++;
            if (d !== b) begin bad++; $display("FAIL ovr_data: got %h want %h", d, b); end
        end
        read_reg(stat_off(), d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL ovr_status_empty: got %h want 00", d); end
        read_reg(data_off(), d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL ovr_data_empty: got %h want 00", d); end
    endtask

    task automatic test_rx_glitch_and_framing();
        logic [7:0] d;
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (60) @(negedge clk);
        read_reg(stat_off(), d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL glitch_status: got %h want 00", d); end
        send_rx(8'($urandom), 1'b0);
        repeat (20) @(negedge clk);
        read_reg(stat_off(), d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL framing_status: got %h want 00", d); end
        read_reg(data_off(), d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL framing_data: got %h want 00", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int lows;
        write_reg(data_off(), 8'($urandom));
        write_reg(data_off(), 8'($urandom));
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL rst_mid_txd: got %b want 1", txd); end
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        total++;
        if (lows != 0) begin bad++; $display("FAIL rst_mid_fifo_empty: got %0d low cycles want 0", lows); end
        read_reg(stat_off(), d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL rst_mid_status: got %h want 00", d); end
    endtask

    initial begin
        test_reset();
        test_tx_single(8'h55);
        test_tx_single(8'($urandom));
        test_status_write_ignored();
        test_back_to_back();
        test_rx_single(8'hA3);
        test_rx_single(8'($urandom));
        test_rx_overrun();
        test_rx_glitch_and_framing();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_mmio_responder.md
# uart_mmio_responder

Memory-mapped UART peripheral at the far end of the CPU's UART MMIO port (byte window 0xAAAAA400–0xAAAAA407). It answers the memory controller's per-cycle register strobes (write = transmit, read = receive or status) and serializes and deserializes 8N1 frames on the board pins. TX and RX each have a FIFO, so software can burst bytes without polling every bit time.

## Interface
Parameters:
- BAUD_DIV, 868 — clk cycles per bit (100 MHz / 115200); legal ≥ 4.
- FIFO_DEPTH, 16 — entries per FIFO; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- tx_wen  in  1  write strobe for this window, one cycle per access.
- rx_ren  in  1  read strobe for this window, one cycle per access.
- uart_din  in  8  write data, valid with tx_wen.
- uart_addr  in  3  byte offset in the window.
- uart_dout  out  8  read data, combinational from uart_addr and current state.
- tx_full  out  1  TX FIFO full.
- rx_data_present  out  1  RX FIFO non-empty.
- txd  out  1  serial output; idles high.
- rxd  in  1  serial input; asynchronous.

## Operation
- Register decode uses only uart_addr[2]. Offsets 0–3 all map to the DATA register; offsets 4–7 all map to the STATUS register.
- DATA write: if tx_wen and TX FIFO not full, push uart_din. If the FIFO is full, the write is silently dropped.
- DATA read: uart_dout = RX FIFO head, or 0x00 when the FIFO is empty. If rx_ren and the FIFO is non-empty, pop at the end of that cycle. If the FIFO is empty, the read has no effect.
- STATUS read: uart_dout = {5'b0, rx_overrun, tx_full, rx_data_present}. If rx_ren targets STATUS, rx_overrun clears at the end of that cycle. Writes to STATUS are ignored.
- uart_dout is valid in the same cycle as the strobe, because the controller registers it on the strobe's clock edge.
- TX FSM states and transitions:
  - IDLE → START when the FIFO is non-empty; pop the byte.
  - START → DATA after one bit period; txd = 0 during START.
  - DATA sends 8 bits, LSB first, one bit period each.
  - DATA → STOP; txd = 1 for one bit period.
  - STOP → START directly if the FIFO is non-empty, otherwise → IDLE. Back-to-back frames therefore have no idle gap.
- RX input: rxd passes through a 2-flop synchronizer.
- RX FSM states and transitions:
  - IDLE → START on a falling edge of the synchronized rxd.
  - START waits BAUD_DIV/2 cycles (integer division). If rxd is still low → DATA; otherwise it was a glitch → IDLE.
  - DATA samples 8 bits, one every BAUD_DIV cycles, LSB first.
  - STOP samples after a further BAUD_DIV cycles. If the stop bit is 1, push the byte. If it is 0 (framing error), drop the byte.
  - STOP → IDLE in all cases.
- RX push when the FIFO is full: the byte is dropped and rx_overrun is set.
- Push and pop in the same cycle on a full RX FIFO: both happen and no overrun is flagged.
- Push and pop in the same cycle on an empty TX FIFO: the FSM only pops when the FIFO is non-empty, so the pushed byte stays and is popped next cycle.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH. Full and empty are derived from the pointer MSB.
- Baud counters count down from BAUD_DIV−1 to 0 and reload.

## Timing
- Reset values:
  - txd = 1, tx_full = 0, rx_data_present = 0, rx_overrun = 0.
  - Both FSMs in IDLE; FIFOs empty; all counters 0.
  - uart_dout = 0x00 for either offset.
- Reset asserted mid-frame aborts the frame: txd = 1 on the next cycle. A partially received byte is discarded.
- tx_full asserts in the cycle after the push that fills the FIFO.
- TX latency, push into an idle TX path:
  - Push at edge N; FSM pops at edge N+1; txd falls at edge N+2.
  - One frame is 10·BAUD_DIV cycles.
- RX latency:
  - The 2-flop synchronizer adds 2 cycles.
  - rx_data_present rises one cycle after the stop-bit sample edge.
  - Stop-bit sample edge ≈ 2 + BAUD_DIV/2 + 9·BAUD_DIV cycles after the line falls.
- rx_data_present falls in the cycle after the pop of the last entry.

## Structure
- Package uart_pkg holds:
  - UART_DATA_SEL = 1'b0, UART_STAT_SEL = 1'b1 (values of uart_addr[2]).
  - Status bit indices: RXDP = 0, TXFULL = 1, OVR = 2.
  - Enums tx_state_t {IDLE, START, DATA, STOP} and rx_state_t {IDLE, START, DATA, STOP}.
- Sub-module uart_fifo (parameter DEPTH, width 8; push, pop, din, dout, full, empty), instantiated twice. dout shows the head combinationally.
- The TX and RX FSMs live in the top module.

## Test plan
All scenarios run with BAUD_DIV = 4 and FIFO_DEPTH = 4.
1. After reset, with no strobes: txd = 1; STATUS read (addr 4) → 0x00; DATA read (addr 0) → 0x00.
2. Write 0x55 to addr 0 → txd low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. Frame begins 2 cycles after the strobe.
3. Write 5 bytes back-to-back while the TX FSM is busy → tx_full = 1 after the FIFO fills. The 5th byte is dropped and exactly 4 frames appear on txd (the first byte leaves the FIFO immediately, so choose timing accordingly and check the count).
4. Drive an rxd frame for 0xA3 → rx_data_present = 1, STATUS reads 0x01. DATA read returns 0xA3 in the strobe cycle; rx_data_present = 0 on the next cycle.
5. Send 5 RX frames without reading → STATUS reads 0x05 (overrun set) and a second STATUS read reads 0x01. Four DATA reads return the first 4 bytes in order.
6. Variants:
   - Drive a 1-cycle low glitch on rxd → nothing pushed.
   - Drive a frame with stop bit = 0 → nothing pushed.
   - Assert rst mid-TX-frame → txd = 1 next cycle and the FIFO is empty.
